// File: rtl/jelly_img_grad_region_accumulator_if.sv
// Pixel input stream and per-region result stream of the gradient region accumulator.
// master: upstream/downstream side (drives pixels and m_ready); slave: the accumulator.
interface jelly_img_grad_region_accumulator_if #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int REGION_WIDTH = 2,
  parameter int SUM_WIDTH    = 32,
  parameter int WSUM_WIDTH   = 32
) ();
  logic                           s_img_line_first;
  logic                           s_img_line_last;
  logic                           s_img_pixel_first;
  logic                           s_img_pixel_last;
  logic                           s_img_de;
  logic signed [X_WIDTH-1:0]      s_img_x;
  logic signed [Y_WIDTH-1:0]      s_img_y;
  logic        [WEIGHT_WIDTH-1:0] s_img_weight;
  logic        [REGION_WIDTH-1:0] s_img_region;
  logic                           s_img_valid;

  logic        [REGION_WIDTH-1:0] m_region;
  logic signed [SUM_WIDTH-1:0]    m_sum_x;
  logic signed [SUM_WIDTH-1:0]    m_sum_y;
  logic        [WSUM_WIDTH-1:0]   m_sum_w;
  logic                           m_sat;
  logic                           m_last;
  logic                           m_valid;
  logic                           m_ready;

  modport master (
    output s_img_line_first, s_img_line_last, s_img_pixel_first, s_img_pixel_last,
    output s_img_de, s_img_x, s_img_y, s_img_weight, s_img_region, s_img_valid,
    output m_ready,
    input  m_region, m_sum_x, m_sum_y, m_sum_w, m_sat, m_last, m_valid
  );

  modport slave (
    input  s_img_line_first, s_img_line_last, s_img_pixel_first, s_img_pixel_last,
    input  s_img_de, s_img_x, s_img_y, s_img_weight, s_img_region, s_img_valid,
    input  m_ready,
    output m_region, m_sum_x, m_sum_y, m_sum_w, m_sat, m_last, m_valid
  );
endinterface

// File: rtl/jelly_img_grad_region_accumulator.sv
// Weighted gradient accumulator: sums w*x, w*y and w per region over frame_num
// frames, then snapshots all regions and streams them out one region per beat.
module jelly_img_grad_region_accumulator #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int REGION_NUM   = 4,
  parameter int REGION_WIDTH = 2,
  parameter int FRAME_WIDTH  = 4,
  parameter int SUM_WIDTH    = 32,
  parameter int WSUM_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic [FRAME_WIDTH-1:0] frame_num,
  jelly_img_grad_region_accumulator_if.slave bus,
  output logic                   overflow
);

  localparam int PX_WIDTH  = X_WIDTH + WEIGHT_WIDTH + 1;
  localparam int PY_WIDTH  = Y_WIDTH + WEIGHT_WIDTH + 1;
  localparam int PXY_MAX   = (PX_WIDTH > PY_WIDTH) ? PX_WIDTH : PY_WIDTH;
  localparam int E_WIDTH   = ((SUM_WIDTH > PXY_MAX) ? SUM_WIDTH : PXY_MAX) + 1;
  localparam int EW_WIDTH  = ((WSUM_WIDTH > WEIGHT_WIDTH) ? WSUM_WIDTH : WEIGHT_WIDTH) + 1;

  localparam logic signed [E_WIDTH-1:0] SUM_POS_LIM =
    {{(E_WIDTH-SUM_WIDTH+1){1'b0}}, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [E_WIDTH-1:0] SUM_NEG_LIM =
    {{(E_WIDTH-SUM_WIDTH+1){1'b1}}, {(SUM_WIDTH-1){1'b0}}};
  localparam logic [EW_WIDTH-1:0] WSUM_LIM =
    {{(EW_WIDTH-WSUM_WIDTH){1'b0}}, {WSUM_WIDTH{1'b1}}};

  localparam logic [REGION_WIDTH:0]   REGION_LIMIT = (REGION_WIDTH+1)'(REGION_NUM);
  localparam logic [REGION_WIDTH-1:0] LAST_IDX     = REGION_WIDTH'(REGION_NUM - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  // ---------------- stage 0: input gating ----------------
  logic frame_first;
  logic frame_last;
  logic armed_eff;
  logic region_ok;
  logic contrib;

  logic                           armed_q;
  logic                           s0_valid_q;
  logic                           s0_first_q;
  logic                           s0_last_q;
  logic signed [X_WIDTH-1:0]      s0_x_q;
  logic signed [Y_WIDTH-1:0]      s0_y_q;
  logic        [WEIGHT_WIDTH-1:0] s0_w_q;
  logic        [REGION_WIDTH-1:0] s0_region_q;

  assign frame_first = bus.s_img_valid & bus.s_img_line_first & bus.s_img_pixel_first;
  assign frame_last  = bus.s_img_valid & bus.s_img_line_last  & bus.s_img_pixel_last;
  // The frame-first pixel arms the block and itself already contributes.
  assign armed_eff   = armed_q | frame_first;
  assign region_ok   = ({1'b0, bus.s_img_region} < REGION_LIMIT);
  assign contrib     = bus.s_img_valid & bus.s_img_de & region_ok & armed_eff;

  // Register gated pixel data and frame markers; nothing counts before arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q     <= 1'b0;
      s0_valid_q  <= 1'b0;
      s0_first_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_x_q      <= '0;
      s0_y_q      <= '0;
      s0_w_q      <= '0;
      s0_region_q <= '0;
    end else if (cke) begin
      armed_q     <= armed_eff;
      s0_valid_q  <= contrib;
      s0_first_q  <= frame_first;
      s0_last_q   <= frame_last & armed_eff;
      s0_x_q      <= contrib ? bus.s_img_x      : '0;
      s0_y_q      <= contrib ? bus.s_img_y      : '0;
      s0_w_q      <= contrib ? bus.s_img_weight : '0;
      s0_region_q <= contrib ? bus.s_img_region : '0;
    end
  end

  // ---------------- stage 1: products ----------------
  logic signed [PX_WIDTH-1:0] prod_x;
  logic signed [PY_WIDTH-1:0] prod_y;

  assign prod_x = PX_WIDTH'($signed({1'b0, s0_w_q})) * PX_WIDTH'(s0_x_q);
  assign prod_y = PY_WIDTH'($signed({1'b0, s0_w_q})) * PY_WIDTH'(s0_y_q);

  logic                           s1_valid_q;
  logic                           s1_first_q;
  logic                           s1_last_q;
  logic signed [PX_WIDTH-1:0]     s1_px_q;
  logic signed [PY_WIDTH-1:0]     s1_py_q;
  logic        [WEIGHT_WIDTH-1:0] s1_w_q;
  logic        [REGION_WIDTH-1:0] s1_region_q;

  // Register signed weighted gradients alongside the markers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_px_q     <= '0;
      s1_py_q     <= '0;
      s1_w_q      <= '0;
      s1_region_q <= '0;
    end else if (cke) begin
      s1_valid_q  <= s0_valid_q;
      s1_first_q  <= s0_first_q;
      s1_last_q   <= s0_last_q;
      s1_px_q     <= prod_x;
      s1_py_q     <= prod_y;
      s1_w_q      <= s0_w_q;
      s1_region_q <= s0_region_q;
    end
  end

  // ---------------- stage 2: saturating accumulation ----------------
  logic signed [SUM_WIDTH-1:0]  acc_x_q [REGION_NUM];
  logic signed [SUM_WIDTH-1:0]  acc_y_q [REGION_NUM];
  logic        [WSUM_WIDTH-1:0] acc_w_q [REGION_NUM];
  logic        [REGION_NUM-1:0] sat_q;
  logic signed [SUM_WIDTH-1:0]  acc_x_d [REGION_NUM];
  logic signed [SUM_WIDTH-1:0]  acc_y_d [REGION_NUM];
  logic        [WSUM_WIDTH-1:0] acc_w_d [REGION_NUM];
  logic        [REGION_NUM-1:0] sat_d;

  logic signed [E_WIDTH-1:0]    sum_x;
  logic signed [E_WIDTH-1:0]    sum_y;
  logic        [EW_WIDTH-1:0]   sum_w;

  logic [FRAME_WIDTH-1:0] fcnt_q;
  logic [FRAME_WIDTH-1:0] flen_q;
  logic [FRAME_WIDTH-1:0] flen_new;
  logic [FRAME_WIDTH-1:0] flen_eff;
  logic [FRAME_WIDTH:0]   fcnt_inc;
  logic                   acc_clear;
  logic                   snap_pend_q;

  assign acc_clear = s1_first_q && (fcnt_q == '0);
  assign flen_new  = (frame_num == '0) ? FRAME_WIDTH'(1) : frame_num;
  assign flen_eff  = acc_clear ? flen_new : flen_q;
  assign fcnt_inc  = (FRAME_WIDTH+1)'(fcnt_q) + (FRAME_WIDTH+1)'(1);

  // Next accumulator values: optional clear at integration start, then add
  // the current pixel so the first pixel loads directly into a clean region.
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    acc_w_d = acc_w_q;
    sat_d   = sat_q;
    sum_x   = '0;
    sum_y   = '0;
    sum_w   = '0;
    if (acc_clear) begin
      for (int unsigned i = 0; i < REGION_NUM; i++) begin
        acc_x_d[i] = '0;
        acc_y_d[i] = '0;
        acc_w_d[i] = '0;
      end
      sat_d = '0;
    end
    if (s1_valid_q) begin
      for (int unsigned i = 0; i < REGION_NUM; i++) begin
        if (s1_region_q == REGION_WIDTH'(i)) begin
          sum_x = E_WIDTH'(acc_x_d[i]) + E_WIDTH'(s1_px_q);
          sum_y = E_WIDTH'(acc_y_d[i]) + E_WIDTH'(s1_py_q);
          sum_w = EW_WIDTH'(acc_w_d[i]) + EW_WIDTH'(s1_w_q);
          if (sum_x > SUM_POS_LIM) begin
            acc_x_d[i] = SUM_POS_LIM[SUM_WIDTH-1:0];
            sat_d[i]   = 1'b1;
          end else if (sum_x < SUM_NEG_LIM) begin
            acc_x_d[i] = SUM_NEG_LIM[SUM_WIDTH-1:0];
            sat_d[i]   = 1'b1;
          end else begin
            acc_x_d[i] = sum_x[SUM_WIDTH-1:0];
          end
          if (sum_y > SUM_POS_LIM) begin
            acc_y_d[i] = SUM_POS_LIM[SUM_WIDTH-1:0];
            sat_d[i]   = 1'b1;
          end else if (sum_y < SUM_NEG_LIM) begin
            acc_y_d[i] = SUM_NEG_LIM[SUM_WIDTH-1:0];
            sat_d[i]   = 1'b1;
          end else begin
            acc_y_d[i] = sum_y[SUM_WIDTH-1:0];
          end
          if (sum_w > WSUM_LIM) begin
            acc_w_d[i] = '1;
            sat_d[i]   = 1'b1;
          end else begin
            acc_w_d[i] = sum_w[WSUM_WIDTH-1:0];
          end
        end
      end
    end
  end

  // Commit accumulators and count frames; the snapshot request is a one-cycle
  // pulse raised with the last pixel so the snapshot sees the complete sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REGION_NUM; i++) begin
        acc_x_q[i] <= '0;
        acc_y_q[i] <= '0;
        acc_w_q[i] <= '0;
      end
      sat_q       <= '0;
      fcnt_q      <= '0;
      flen_q      <= FRAME_WIDTH'(1);
      snap_pend_q <= 1'b0;
    end else begin
      snap_pend_q <= 1'b0;
      if (cke) begin
        acc_x_q <= acc_x_d;
        acc_y_q <= acc_y_d;
        acc_w_q <= acc_w_d;
        sat_q   <= sat_d;
        if (acc_clear) begin
          flen_q <= flen_new;
        end
        if (s1_last_q) begin
          if (fcnt_inc == {1'b0, flen_eff}) begin
            fcnt_q      <= '0;
            snap_pend_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_inc[FRAME_WIDTH-1:0];
          end
        end
      end
    end
  end

  // ---------------- output buffer and stream FSM ----------------
  state_t                        state_q;
  logic        [REGION_WIDTH-1:0] idx_q;
  logic signed [SUM_WIDTH-1:0]   buf_x_q [REGION_NUM];
  logic signed [SUM_WIDTH-1:0]   buf_y_q [REGION_NUM];
  logic        [WSUM_WIDTH-1:0]  buf_w_q [REGION_NUM];
  logic        [REGION_NUM-1:0]  buf_sat_q;
  logic        [REGION_WIDTH-1:0] m_region_q;
  logic signed [SUM_WIDTH-1:0]   m_sum_x_q;
  logic signed [SUM_WIDTH-1:0]   m_sum_y_q;
  logic        [WSUM_WIDTH-1:0]  m_sum_w_q;
  logic                          m_sat_q;
  logic                          m_last_q;
  logic                          m_valid_q;
  logic                          overflow_q;

  logic                          hs;
  logic                          done;
  logic                          snap_take;
  logic        [REGION_WIDTH-1:0] nxt_idx;
  logic signed [SUM_WIDTH-1:0]   nxt_x;
  logic signed [SUM_WIDTH-1:0]   nxt_y;
  logic        [WSUM_WIDTH-1:0]  nxt_w;
  logic                          nxt_sat;

  assign hs        = m_valid_q & bus.m_ready;
  assign done      = hs & m_last_q;
  // A snapshot landing on the final handshake is taken without loss.
  assign snap_take = snap_pend_q & ((state_q == ST_IDLE) | done);

  // Select the buffered region that follows the current beat.
  always_comb begin
    nxt_idx = idx_q + REGION_WIDTH'(1);
    nxt_x   = '0;
    nxt_y   = '0;
    nxt_w   = '0;
    nxt_sat = 1'b0;
    for (int unsigned i = 0; i < REGION_NUM; i++) begin
      if (nxt_idx == REGION_WIDTH'(i)) begin
        nxt_x   = buf_x_q[i];
        nxt_y   = buf_y_q[i];
        nxt_w   = buf_w_q[i];
        nxt_sat = buf_sat_q[i];
      end
    end
  end

  // Snapshot into the buffer, stream regions 0..REGION_NUM-1, flag drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      for (int unsigned i = 0; i < REGION_NUM; i++) begin
        buf_x_q[i] <= '0;
        buf_y_q[i] <= '0;
        buf_w_q[i] <= '0;
      end
      buf_sat_q  <= '0;
      m_region_q <= '0;
      m_sum_x_q  <= '0;
      m_sum_y_q  <= '0;
      m_sum_w_q  <= '0;
      m_sat_q    <= 1'b0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (snap_take) begin
        state_q    <= ST_SEND;
        idx_q      <= '0;
        buf_x_q    <= acc_x_q;
        buf_y_q    <= acc_y_q;
        buf_w_q    <= acc_w_q;
        buf_sat_q  <= sat_q;
        m_region_q <= '0;
        m_sum_x_q  <= acc_x_q[0];
        m_sum_y_q  <= acc_y_q[0];
        m_sum_w_q  <= acc_w_q[0];
        m_sat_q    <= sat_q[0];
        m_last_q   <= (REGION_NUM == 1);
        m_valid_q  <= 1'b1;
      end else if (done) begin
        state_q   <= ST_IDLE;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else if (hs) begin
        idx_q      <= nxt_idx;
        m_region_q <= nxt_idx;
        m_sum_x_q  <= nxt_x;
        m_sum_y_q  <= nxt_y;
        m_sum_w_q  <= nxt_w;
        m_sat_q    <= nxt_sat;
        m_last_q   <= (nxt_idx == LAST_IDX);
      end
      if (snap_pend_q && !snap_take) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.m_region = m_region_q;
  assign bus.m_sum_x  = m_sum_x_q;
  assign bus.m_sum_y  = m_sum_y_q;
  assign bus.m_sum_w  = m_sum_w_q;
  assign bus.m_sat    = m_sat_q;
  assign bus.m_last   = m_last_q;
  assign bus.m_valid  = m_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_jelly_img_grad_region_accumulator.sv
// Directed bench: a 32-bit-sum instance and a 16-bit-sum instance see the same
// pixel stream; expected sums are hand-computed constants.
module tb_jelly_img_grad_region_accumulator;

  localparam int RW = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cke = 1'b1;
  logic [3:0] frame_num = 4'd1;
  logic       ovf32;
  logic       ovf16;
  bit         cke_toggle = 1'b0;

  int checks = 0;
  int errors = 0;

  jelly_img_grad_region_accumulator_if #(.REGION_WIDTH(RW)) if32 ();
  jelly_img_grad_region_accumulator_if #(.REGION_WIDTH(RW), .SUM_WIDTH(16)) if16 ();

  jelly_img_grad_region_accumulator #(
    .REGION_NUM(4), .REGION_WIDTH(RW), .SUM_WIDTH(32), .WSUM_WIDTH(32)
  ) u_dut32 (
    .clk(clk), .reset(reset), .cke(cke), .frame_num(frame_num), .bus(if32), .overflow(ovf32)
  );

  jelly_img_grad_region_accumulator #(
    .REGION_NUM(4), .REGION_WIDTH(RW), .SUM_WIDTH(16), .WSUM_WIDTH(32)
  ) u_dut16 (
    .clk(clk), .reset(reset), .cke(cke), .frame_num(frame_num), .bus(if16), .overflow(ovf16)
  );

  assign if16.s_img_line_first  = if32.s_img_line_first;
  assign if16.s_img_line_last   = if32.s_img_line_last;
  assign if16.s_img_pixel_first = if32.s_img_pixel_first;
  assign if16.s_img_pixel_last  = if32.s_img_pixel_last;
  assign if16.s_img_de          = if32.s_img_de;
  assign if16.s_img_x           = if32.s_img_x;
  assign if16.s_img_y           = if32.s_img_y;
  assign if16.s_img_weight      = if32.s_img_weight;
  assign if16.s_img_region      = if32.s_img_region;
  assign if16.s_img_valid       = if32.s_img_valid;
  assign if16.m_ready           = if32.m_ready;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cke_toggle) cke = ~cke;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present one pixel and hold it until an edge with cke high has sampled it.
  task automatic px(input bit lf, input bit ll, input bit pf, input bit pl, input bit de,
                    input int x, input int y, input int w, input int r);
    bit sampled;
    int n;
    if32.s_img_valid       = 1'b1;
    if32.s_img_line_first  = lf;
    if32.s_img_line_last   = ll;
    if32.s_img_pixel_first = pf;
    if32.s_img_pixel_last  = pl;
    if32.s_img_de          = de;
    if32.s_img_x           = 8'(x);
    if32.s_img_y           = 8'(y);
    if32.s_img_weight      = 8'(w);
    if32.s_img_region      = RW'(r);
    sampled = 1'b0;
    n = 0;
    while (!sampled && n < 100) begin
      @(posedge clk);
      sampled = cke;
      n++;
    end
    #1;
  endtask

  task automatic idle();
    if32.s_img_valid       = 1'b0;
    if32.s_img_line_first  = 1'b0;
    if32.s_img_line_last   = 1'b0;
    if32.s_img_pixel_first = 1'b0;
    if32.s_img_pixel_last  = 1'b0;
    if32.s_img_de          = 1'b0;
  endtask

  task automatic frame2x2(input int x, input int y, input int w, input int r);
    px(1, 0, 1, 0, 1, x, y, w, r);
    px(1, 0, 0, 1, 1, x, y, w, r);
    px(0, 1, 1, 0, 1, x, y, w, r);
    px(0, 1, 0, 1, 1, x, y, w, r);
    idle();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!if32.m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, longint'(if32.m_valid), 1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (if32.m_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Drain one result; region 'hot' carries the given sums, all others zero.
  task automatic collect(input string tag, input int hot, input longint ex, input longint ex16,
                         input longint ey, input longint ew, input bit sat32, input bit sat16);
    if32.m_ready = 1'b1;
    wait_valid(tag);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("%s_b%0d_region", tag, b), longint'(if32.m_region), b);
      check($sformatf("%s_b%0d_x", tag, b), longint'($signed(if32.m_sum_x)), (b == hot) ? ex : 0);
      check($sformatf("%s_b%0d_y", tag, b), longint'($signed(if32.m_sum_y)), (b == hot) ? ey : 0);
      check($sformatf("%s_b%0d_w", tag, b), longint'(if32.m_sum_w), (b == hot) ? ew : 0);
      check($sformatf("%s_b%0d_sat", tag, b), longint'(if32.m_sat), (b == hot) ? longint'(sat32) : 0);
      check($sformatf("%s_b%0d_last", tag, b), longint'(if32.m_last), (b == 3) ? 1 : 0);
      check($sformatf("%s_b%0d_x16", tag, b), longint'($signed(if16.m_sum_x)), (b == hot) ? ex16 : 0);
      check($sformatf("%s_b%0d_sat16", tag, b), longint'(if16.m_sat), (b == hot) ? longint'(sat16) : 0);
      @(negedge clk);
    end
    check({tag, "_end"}, longint'(if32.m_valid), 0);
  endtask

  initial begin
    if32.m_ready = 1'b1;
    if32.s_img_x = '0;
    if32.s_img_y = '0;
    if32.s_img_weight = '0;
    if32.s_img_region = '0;
    idle();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", longint'(if32.m_valid), 0);
    check("rst_last", longint'(if32.m_last), 0);
    check("rst_sat", longint'(if32.m_sat), 0);
    check("rst_region", longint'(if32.m_region), 0);
    check("rst_x", longint'(if32.m_sum_x), 0);
    check("rst_y", longint'(if32.m_sum_y), 0);
    check("rst_w", longint'(if32.m_sum_w), 0);
    check("rst_ovf", longint'(ovf32), 0);
    reset = 1'b0;
    @(negedge clk);

    // pixels before the first frame-first are ignored, even a frame-last
    frame_num = 4'd1;
    px(0, 1, 0, 1, 1, 100, 100, 100, 1);
    px(0, 0, 0, 0, 1, 50, 50, 50, 1);
    idle();
    quiet("prearm_quiet", 8);

    // 2x2 frame with a de=0 pixel and an out-of-range region pixel mixed in
    px(1, 0, 1, 0, 1, 3, -2, 5, 1);
    px(0, 0, 0, 0, 0, 9, 9, 9, 1);
    px(0, 0, 0, 0, 1, 50, 50, 50, 5);
    px(1, 0, 0, 1, 1, 3, -2, 5, 1);
    px(0, 1, 1, 0, 1, 3, -2, 5, 1);
    px(0, 1, 0, 1, 1, 3, -2, 5, 1);
    idle();
    repeat (3) @(negedge clk);
    check("lat_e2", longint'(if32.m_valid), 0);
    @(negedge clk);
    check("lat_e3", longint'(if32.m_valid), 1);
    collect("t1", 1, 60, 60, -40, 20, 0, 0);

    // three-frame integration
    frame_num = 4'd3;
    frame2x2(3, -2, 5, 1);
    quiet("t2_f1_quiet", 8);
    frame2x2(3, -2, 5, 1);
    quiet("t2_f2_quiet", 8);
    frame2x2(3, -2, 5, 1);
    collect("t2", 1, 180, 180, -120, 60, 0, 0);

    // result dropped while the previous one is still stalled
    frame_num = 4'd1;
    if32.m_ready = 1'b0;
    frame2x2(3, -2, 5, 0);
    wait_valid("t3a");
    frame2x2(1, 1, 1, 0);
    repeat (8) @(negedge clk);
    check("t3_ovf", longint'(ovf32), 1);
    check("t3_ovf16", longint'(ovf16), 1);
    check("t3_hold_valid", longint'(if32.m_valid), 1);
    check("t3_hold_region", longint'(if32.m_region), 0);
    check("t3_hold_x", longint'($signed(if32.m_sum_x)), 60);
    collect("t3", 0, 60, 60, -40, 20, 0, 0);
    quiet("t3_drop_quiet", 10);

    // reset during beat 2 abandons the stream and clears overflow
    frame2x2(3, -2, 5, 1);
    if32.m_ready = 1'b1;
    wait_valid("t4a");
    @(negedge clk);
    @(negedge clk);
    check("t4_beat2", longint'(if32.m_region), 2);
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_valid", longint'(if32.m_valid), 0);
    check("t4_rst_ovf", longint'(ovf32), 0);
    reset = 1'b0;
    @(negedge clk);
    frame2x2(-4, 7, 9, 3);
    collect("t4", 3, -144, -144, 252, 36, 0, 0);

    // saturation in the 16-bit instance; invalid region pixel in between
    px(1, 1, 1, 0, 1, 127, -1, 255, 2);
    px(0, 0, 0, 0, 1, 127, -1, 255, 5);
    px(1, 1, 0, 1, 1, 127, -1, 255, 2);
    idle();
    collect("t5", 2, 64770, 32767, -510, 510, 0, 1);

    // clock enable toggling every cycle
    cke_toggle = 1'b1;
    frame2x2(3, -2, 5, 1);
    collect("t6", 1, 60, 60, -40, 20, 0, 0);
    @(posedge clk);
    #2;
    cke_toggle = 1'b0;
    cke = 1'b1;

    // single-pixel frame
    px(1, 1, 1, 1, 1, -5, 6, 10, 0);
    idle();
    collect("t7", 0, -50, -50, 60, 10, 0, 0);
    check("final_ovf", longint'(ovf32), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
